// File: rtl/trig_clk_sched_if.sv
// Control/status bundle for trig_clk_sched: run request, timing setup and generated clock/status.
// TRIG_CLK_SCHED_DUTY_EN adds the separate low_period setting.
interface trig_clk_sched_if #(
    parameter int CNT_W   = 20,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic [CNT_W-1:0]   half_period;
`ifdef TRIG_CLK_SCHED_DUTY_EN
    logic [CNT_W-1:0]   low_period;
`endif
    logic [BURST_W-1:0] burst_len;
    logic               trig_clk;
    logic               rise_stb;
    logic               fall_stb;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulses_done;

    modport master (
`ifdef TRIG_CLK_SCHED_DUTY_EN
        output low_period,
`endif
        output start, stop, half_period, burst_len,
        input  trig_clk, rise_stb, fall_stb, busy, done, pulses_done
    );

    modport slave (
`ifdef TRIG_CLK_SCHED_DUTY_EN
        input  low_period,
`endif
        input  start, stop, half_period, burst_len,
        output trig_clk, rise_stb, fall_stb, busy, done, pulses_done
    );
endinterface

// File: rtl/trig_clk_sched.sv
// Programmable burst/continuous clock source for trigger cells, with edge strobes and status.
// Optional TRIG_CLK_SCHED_DUTY_EN: independent LOW-level length from low_period.
module trig_clk_sched #(
    parameter int CNT_W   = 20,
    parameter int BURST_W = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    trig_clk_sched_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   hp, lp, hp_in, lp_in;
    logic [BURST_W-1:0] bl, pcnt, pcnt_nxt;
    logic               stop_pend, stop_nxt;
    logic               accept;
    logic               trig_q, rise_q, fall_q, busy_q, done_q;

    // A zero level length would stall the counter; clamp to one cycle.
    function automatic logic [CNT_W-1:0] floor_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    assign hp_in = floor_one(bus.half_period);
`ifdef TRIG_CLK_SCHED_DUTY_EN
    assign lp_in = floor_one(bus.low_period);
`else
    assign lp_in = hp_in;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pcnt_nxt  = pcnt;
        stop_nxt  = stop_pend;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    accept    = 1'b1;
                    state_nxt = HIGH;
                    cnt_nxt   = hp_in - CNT_ONE;
                    pcnt_nxt  = '0;
                end
            end
            HIGH: begin
                stop_nxt = stop_pend | bus.stop;
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = lp - CNT_ONE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            LOW: begin
                stop_nxt = stop_pend | bus.stop;
                if (cnt == '0) begin
                    // Period boundary: a stop seen this very cycle still ends the run here.
                    pcnt_nxt = pcnt + BURST_ONE;
                    if (((bl != '0) && (pcnt_nxt == bl)) || stop_nxt) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = hp - CNT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                stop_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hp        <= '0;
            lp        <= '0;
            bl        <= '0;
            pcnt      <= '0;
            stop_pend <= 1'b0;
            trig_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pcnt      <= pcnt_nxt;
            stop_pend <= stop_nxt;
            if (accept) begin
                hp <= hp_in;
                lp <= lp_in;
                bl <= bus.burst_len;
            end
            trig_q <= (state_nxt == HIGH);
            rise_q <= (state_nxt == HIGH) && (state != HIGH);
            fall_q <= (state_nxt == LOW) && (state == HIGH);
            busy_q <= (state_nxt == HIGH) || (state_nxt == LOW);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.trig_clk    = trig_q;
    assign bus.rise_stb    = rise_q;
    assign bus.fall_stb    = fall_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_done = pcnt;
endmodule

// File: tb/tb_trig_clk_sched.sv
// Directed bench for trig_clk_sched: cycle-by-cycle waveform checks against a period model.
module tb_trig_clk_sched;
    logic Clock = 1'b0;
    logic Reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 Clock = ~Clock;

    trig_clk_sched_if bus ();

    trig_clk_sched dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_run(input int hp, input int bl, input int lp);
        bus.half_period = 20'(hp);
        bus.burst_len   = 8'(bl);
`ifdef TRIG_CLK_SCHED_DUTY_EN
        bus.low_period  = 20'(lp);
`endif
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    // Expects n full periods (hpe high, lpe low), then one DONE cycle, then idle.
    task automatic check_run(input int hpe, input int lpe, input int n, input int stop_cyc,
                             input int poke_cyc, input bit start_in_done, input string tag);
        int p    = hpe + lpe;
        int last = n * p + 1;
        int pos;
        logic e_trig, e_rise, e_fall, e_busy, e_done;
        int e_pd;
        for (int c = 1; c <= last; c++) begin
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (c < last) begin
                pos    = (c - 1) % p;
                e_trig = (pos < hpe);
                e_rise = (pos == 0);
                e_fall = (pos == hpe);
                e_busy = 1'b1;
                e_done = 1'b0;
                e_pd   = (c - 1) / p;
            end else begin
                e_trig = 1'b0;
                e_rise = 1'b0;
                e_fall = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b1;
                e_pd   = n;
            end
            chk($sformatf("%s.c%0d.trig", tag, c), 32'(bus.trig_clk), 32'(e_trig));
            chk($sformatf("%s.c%0d.rise", tag, c), 32'(bus.rise_stb), 32'(e_rise));
            chk($sformatf("%s.c%0d.fall", tag, c), 32'(bus.fall_stb), 32'(e_fall));
            chk($sformatf("%s.c%0d.busy", tag, c), 32'(bus.busy), 32'(e_busy));
            chk($sformatf("%s.c%0d.done", tag, c), 32'(bus.done), 32'(e_done));
            chk($sformatf("%s.c%0d.pd", tag, c), 32'(bus.pulses_done), 32'(e_pd & 8'hff));
            if (c == stop_cyc) bus.stop = 1'b1;
            if (c == poke_cyc) begin
                bus.start       = 1'b1;
                bus.half_period = 20'd7;
                bus.burst_len   = 8'd9;
            end
            if (c == last && start_in_done) bus.start = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk({tag, ".post.busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".post.done"}, 32'(bus.done), 32'd0);
        chk({tag, ".post.trig"}, 32'(bus.trig_clk), 32'd0);
        chk({tag, ".post.pd"}, 32'(bus.pulses_done), 32'(n & 8'hff));
        tick();
        chk({tag, ".idle.busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".idle.rise"}, 32'(bus.rise_stb), 32'd0);
        chk({tag, ".idle.pd"}, 32'(bus.pulses_done), 32'(n & 8'hff));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n         = 1'b1;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.half_period = '0;
        bus.burst_len   = '0;
`ifdef TRIG_CLK_SCHED_DUTY_EN
        bus.low_period  = '0;
`endif
        #2 Reset_n = 1'b0;
        #1;
        chk("rst.trig", 32'(bus.trig_clk), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.rise", 32'(bus.rise_stb), 32'd0);
        chk("rst.fall", 32'(bus.fall_stb), 32'd0);
        chk("rst.pd", 32'(bus.pulses_done), 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        chk("idle.busy", 32'(bus.busy), 32'd0);
        chk("idle.trig", 32'(bus.trig_clk), 32'd0);

        // Burst of two periods, 3 cycles per level.
        start_run(3, 2, 3);
        check_run(3, 3, 2, 0, 0, 1'b0, "burst");

        // Zero half period behaves as one.
        start_run(0, 1, 0);
        check_run(1, 1, 1, 0, 0, 1'b0, "hp0");

        // Continuous; stop during 2nd HIGH cycle of period 3 lets that period finish.
        start_run(4, 0, 4);
        check_run(4, 4, 3, 18, 0, 1'b0, "stop");

        // Restart mid-run with new settings is ignored; start in DONE is ignored.
        start_run(2, 2, 2);
        check_run(2, 2, 2, 0, 3, 1'b1, "ign");

        // start together with stop in IDLE: nothing happens, pulses_done holds.
        bus.half_period = 20'd3;
        bus.burst_len   = 8'd1;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss.busy", 32'(bus.busy), 32'd0);
        chk("ss.trig", 32'(bus.trig_clk), 32'd0);
        chk("ss.rise", 32'(bus.rise_stb), 32'd0);
        chk("ss.pd", 32'(bus.pulses_done), 32'd2);
        tick();
        chk("ss.busy2", 32'(bus.busy), 32'd0);

        // Reset in the middle of a continuous run (start of period 2).
        start_run(5, 0, 5);
        for (int i = 0; i < 10; i++) tick();
        chk("mid.rise", 32'(bus.rise_stb), 32'd1);
        chk("mid.pd", 32'(bus.pulses_done), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("mid.rst.trig", 32'(bus.trig_clk), 32'd0);
        chk("mid.rst.busy", 32'(bus.busy), 32'd0);
        chk("mid.rst.rise", 32'(bus.rise_stb), 32'd0);
        chk("mid.rst.pd", 32'(bus.pulses_done), 32'd0);
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mid.post%0d.busy", i), 32'(bus.busy), 32'd0);
            chk($sformatf("mid.post%0d.trig", i), 32'(bus.trig_clk), 32'd0);
        end

`ifdef TRIG_CLK_SCHED_DUTY_EN
        // Asymmetric duty: 2 high, 5 low, three periods.
        start_run(2, 3, 5);
        check_run(2, 5, 3, 0, 0, 1'b0, "duty");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/trig_clk_sched.md
Name: trig_clk_sched

Overview:
- Programmable clock scheduler for the D/T trigger cells; replaces free-running `forever` clock toggling with a controllable source.
- Divides the system clock into a square wave `trig_clk` that drives a trigger's Clock input.
- Also emits single-cycle edge strobes for use as clock enables.
- Supports burst (N periods) and continuous modes, with a start/stop handshake and status outputs.

Parameters:
- CNT_W, 20, width of the phase counter and `half_period` input.
- BURST_W, 8, width of `burst_len` and `pulses_done`.

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; honoured only in IDLE.
- stop  input  1  request graceful stop; honoured in HIGH/LOW.
- half_period  input  CNT_W  cycles per level; latched on accepted start; 0 treated as 1.
- burst_len  input  BURST_W  periods per run; latched on accepted start; 0 = continuous.
- trig_clk  output  1  generated square wave.
- rise_stb  output  1  1-cycle pulse in the first cycle `trig_clk` is 1.
- fall_stb  output  1  1-cycle pulse in the first cycle `trig_clk` is 0 after HIGH.
- busy  output  1  high in HIGH and LOW.
- done  output  1  1-cycle pulse when a run ends (burst complete or stop).
- pulses_done  output  BURST_W  completed periods in current/last run.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; latched period/length and stop_pending cleared.
- States: IDLE, HIGH, LOW, DONE. `trig_clk` = 1 only in HIGH.
- IDLE:
  - start=1 and stop=0 at edge t: latch `hp = max(half_period,1)` and `bl = burst_len`; clear `pulses_done`.
  - Cycle t+1: HIGH, rise_stb=1, counter=hp-1.
  - start and stop together in IDLE: nothing happens; stop wins.
- HIGH/LOW: counter decrements each cycle. Each level lasts exactly hp cycles, so period = 2*hp, duty 50%.
- HIGH with counter==0: go to LOW, fall_stb=1, reload hp-1.
- LOW with counter==0 (period complete):
  - `pulses_done` += 1 (wraps modulo 2^BURST_W).
  - If (bl!=0 and new count==bl) or stop_pending: go to DONE.
  - Else go to HIGH with rise_stb=1 and reload.
- stop=1 in HIGH/LOW: sets stop_pending. The current period always finishes; no runt pulses.
  - stop arriving in the same cycle as LOW's final count is included in that decision.
- DONE: lasts exactly 1 cycle. done=1, busy=0, trig_clk=0; clears stop_pending; then IDLE.
  - start in DONE is ignored; it may be reasserted in IDLE the next cycle.
- start while busy: ignored. half_period/burst_len changes while busy: no effect.
- All outputs registered; no combinational input-to-output paths.
- `pulses_done` holds its value after DONE until the next accepted start.

Optional Feature:
- Macro: TRIG_CLK_SCHED_DUTY_EN.
- Defined:
  - Adds input `low_period` (CNT_W), latched on start; 0 treated as 1.
  - LOW level lasts `low_period` cycles; HIGH level uses `half_period`. Period = hp+lp.
- Undefined: port absent; LOW level uses `half_period` (50% duty).

Test Plan:
- Reset mid-run: assert Reset_n=0 during HIGH with hp=5 -> trig_clk, busy, strobes, pulses_done all 0 immediately; after release state is IDLE, no output activity without start.
- Burst: hp=3, burst_len=2, start pulse -> trig_clk 1 for 3 cycles, 0 for 3, 1 for 3, 0 for 3 (12 cycles); rise_stb at cycles 1 and 7, fall_stb at 4 and 10; done at cycle 13; pulses_done=2; busy=0 afterwards.
- half_period=0, burst_len=1 -> treated as hp=1: trig_clk 1 one cycle, 0 one cycle, done next cycle, pulses_done=1.
- Continuous with stop: hp=4, burst_len=0; stop pulsed in 2nd cycle of HIGH of period 3 -> period 3 completes in full (8 cycles); done follows; pulses_done=3; no shortened level.
- Ignored requests: start with half_period changed 2->7 mid-run -> period stays 4; start+stop together in IDLE -> stays IDLE, busy=0; start in DONE cycle -> ignored.
- TRIG_CLK_SCHED_DUTY_EN defined: hp=2, lp=5, burst_len=3 -> trig_clk high 2, low 5, three times (21 cycles); done at cycle 22.
